// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by a run-time rate R,
// then N integrators at the output rate, with AXI-stream handshakes on both sides.
module cic_interpolator #(
    parameter int WIDTH     = 16,
    parameter int RMAX      = 2,
    parameter int M         = 1,
    parameter int N         = 2,
    parameter int REG_WIDTH = WIDTH + ((N > $clog2(((RMAX*M)**N)/RMAX)) ?
                                       N : $clog2(((RMAX*M)**N)/RMAX))
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              input_tdata,
    input  logic                          input_tvalid,
    output logic                          input_tready,
    output logic [REG_WIDTH-1:0]          output_tdata,
    output logic                          output_tvalid,
    input  logic                          output_tready,
    input  logic [$clog2(RMAX+1)-1:0]     rate
);

    localparam int RW = $clog2(RMAX+1);

    logic signed [REG_WIDTH-1:0] comb_reg  [N];
    logic signed [REG_WIDTH-1:0] delay_reg [N][M];
    logic signed [REG_WIDTH-1:0] int_reg   [N];
    logic signed [REG_WIDTH-1:0] comb_src  [N];
    logic signed [REG_WIDTH-1:0] int_src   [N];
    logic [RW-1:0]               cycle_reg;
    logic [RW-1:0]               rate_reg;
    logic [RW-1:0]               rate_eff;
    logic [RW-1:0]               reff;
    logic [RW:0]                 cycle_inc;
    logic                        cycle_wrap;
    logic                        in_hs;
    logic                        out_hs;

    assign input_tready  = output_tready & (cycle_reg == '0);
    assign output_tvalid = input_tvalid | (cycle_reg != '0);
    assign in_hs         = input_tvalid & input_tready;
    assign out_hs        = output_tvalid & output_tready;
    assign output_tdata  = int_reg[N-1];

    // Clamp the requested rate into 1..RMAX.
    // NOTE: every branch assigns rate_eff, so no latch is inferred.
    always_comb begin
        if (rate == '0)
            rate_eff = RW'(1);
        else if (rate > RW'(RMAX))
            rate_eff = RW'(RMAX);
        else
            rate_eff = rate;
    end

    // A new sample starts its burst with the live rate; the rest of the burst uses the latched one.
    assign reff       = in_hs ? rate_eff : rate_reg;
    assign cycle_inc  = {1'b0, cycle_reg} + (RW+1)'(1);
    assign cycle_wrap = cycle_inc >= {1'b0, reff};

    always_comb begin
        comb_src[0] = {{(REG_WIDTH-WIDTH){input_tdata[WIDTH-1]}}, input_tdata};
        int_src[0]  = (cycle_reg == '0) ? comb_reg[N-1] : '0;
        for (int k = 1; k < N; k++) begin
            comb_src[k] = comb_reg[k-1];
            int_src[k]  = int_reg[k-1];
        end
    end

    // NOTE: non-blocking updates mean each stage consumes the previous stage's old value,
    // which is exactly the one-register-per-stage pipeline the CIC structure needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stage arrays are small register banks, not RAM, so they are reset
            // explicitly to drop any partial burst.
            cycle_reg <= '0;
            rate_reg  <= RW'(1);
            for (int k = 0; k < N; k++) begin
                comb_reg[k] <= '0;
                int_reg[k]  <= '0;
                for (int j = 0; j < M; j++)
                    delay_reg[k][j] <= '0;
            end
        end else begin
            if (in_hs) begin
                rate_reg <= rate_eff;
                for (int k = 0; k < N; k++) begin
                    comb_reg[k]     <= comb_src[k] - delay_reg[k][M-1];
                    delay_reg[k][0] <= comb_src[k];
                    for (int j = 1; j < M; j++)
                        delay_reg[k][j] <= delay_reg[k][j-1];
                end
            end
            if (out_hs) begin
                cycle_reg <= cycle_wrap ? '0 : cycle_inc[RW-1:0];
                for (int k = 0; k < N; k++)
                    int_reg[k] <= int_reg[k] + int_src[k];
            end
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator at default parameters: impulse, DC, backpressure,
// rate clamping/switching and mid-burst reset, against hand-computed beat sequences.
module tb_cic_interpolator;

    localparam int WIDTH     = 16;
    localparam int REG_WIDTH = 18;

    logic                 clk;
    logic                 rst;
    logic [WIDTH-1:0]     input_tdata;
    logic                 input_tvalid;
    logic                 input_tready;
    logic [REG_WIDTH-1:0] output_tdata;
    logic                 output_tvalid;
    logic                 output_tready;
    logic [1:0]           rate;

    cic_interpolator dut (
        .clk           (clk),
        .rst           (rst),
        .input_tdata   (input_tdata),
        .input_tvalid  (input_tvalid),
        .input_tready  (input_tready),
        .output_tdata  (output_tdata),
        .output_tvalid (output_tvalid),
        .output_tready (output_tready),
        .rate          (rate)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [WIDTH-1:0] stim[$];
    logic signed [WIDTH-1:0] fill;
    int                      idx;
    int                      exp_data[$];
    bit                      exp_in[$];
    int                      switch_beat;
    logic [1:0]              switch_rate;

    task automatic check(input string tag, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Expected input_tready pattern per beat: every beat (R=1) or every other beat (R=2).
    task automatic set_in(input int n, input bit alt);
        exp_in = {};
        for (int i = 0; i < n; i++)
            exp_in.push_back(alt ? (i % 2 == 0) : 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        input_tvalid = 1'b0;
        output_tready = 1'b1;
        switch_beat = -1;
        idx = 0;
        stim = {};
        fill = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs until nbeats output beats complete, checking every cycle with output_tvalid high
    // (stalled or not) against the expected beat value and input acceptance.
    task automatic run_check(input string tag, input int nbeats, input bit stall);
        int b   = 0;
        int cyc = 0;
        bit ihs, ohs;
        while (b < nbeats && cyc < 1000) begin
            if (b == switch_beat) rate = switch_rate;
            output_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            input_tvalid  = 1'b1;
            input_tdata   = (idx < stim.size()) ? stim[idx] : fill;
            @(negedge clk);
            check({tag, " tdata"}, $signed(output_tdata), exp_data[b]);
            check({tag, " tvalid"}, output_tvalid, 1);
            check({tag, " in_ready"}, input_tready, exp_in[b] & output_tready);
            ihs = input_tvalid & input_tready;
            ohs = output_tvalid & output_tready;
            @(posedge clk);
            #1;
            if (ihs) idx++;
            if (ohs) b++;
            cyc++;
        end
        if (b < nbeats) check({tag, " timeout beats"}, b, nbeats);
    endtask

    initial begin
        clk = 1'b0;
        rate = 2'd2;
        input_tdata = '0;

        // Reset state and the combinational reset relationships.
        do_reset();
        rst = 1'b1;
        #1;
        check("reset tdata", $signed(output_tdata), 0);
        check("reset tvalid", output_tvalid, 0);
        check("reset in_ready", input_tready, 1);
        output_tready = 1'b0;
        #1;
        check("reset in_ready low", input_tready, 0);
        input_tvalid = 1'b1;
        #1;
        check("reset tvalid follows", output_tvalid, 1);

        // 1: impulse at R=2.
        do_reset();
        rate = 2'd2;
        stim = '{16'sd1};
        exp_data = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0};
        set_in(14, 1'b1);
        run_check("imp_r2", 14, 1'b0);

        // 2: impulse at R=1 passes at unity gain.
        do_reset();
        rate = 2'd1;
        stim = '{16'sd1};
        exp_data = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        set_in(10, 1'b0);
        run_check("imp_r1", 10, 1'b0);

        // 3: DC 100 at R=2 settles to 200.
        do_reset();
        rate = 2'd2;
        fill = 16'sd100;
        exp_data = '{0, 0, 0, 0, 0, 0, 100, 200, 200, 200, 200, 200, 200, 200, 200, 200};
        set_in(16, 1'b1);
        run_check("dc_r2", 16, 1'b0);

        // 4: impulse at R=2 under random backpressure.
        do_reset();
        rate = 2'd2;
        stim = '{16'sd1};
        exp_data = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0};
        set_in(14, 1'b1);
        run_check("imp_bp", 14, 1'b1);

        // 5a: rate=0 behaves as R=1.
        do_reset();
        rate = 2'd0;
        stim = '{16'sd1};
        exp_data = '{0, 0, 0, 0, 1, 0, 0, 0};
        set_in(8, 1'b0);
        run_check("imp_rate0", 8, 1'b0);

        // 5b: rate=3 behaves as R=2.
        do_reset();
        rate = 2'd3;
        stim = '{16'sd1};
        exp_data = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 0};
        set_in(10, 1'b1);
        run_check("imp_rate3", 10, 1'b0);

        // 5c: switch 2->1 during the first sample's burst; it still gets 2 beats.
        do_reset();
        rate = 2'd2;
        stim = '{16'sd1};
        switch_beat = 1;
        switch_rate = 2'd1;
        exp_data = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        exp_in = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_check("rate_switch", 9, 1'b0);

        // 6: reset in the middle of a burst, then rerun the impulse.
        do_reset();
        rate = 2'd2;
        stim = '{16'sd1};
        exp_data = '{0, 0, 0, 0, 0, 0, 1, 2};
        set_in(8, 1'b1);
        run_check("pre_reset", 7, 1'b0);
        rst = 1'b1;
        input_tvalid = 1'b1;
        output_tready = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset tdata", $signed(output_tdata), 0);
        check("mid reset in_ready", input_tready, 1);
        check("mid reset tvalid", output_tvalid, 1);
        rst = 1'b0;
        idx = 0;
        exp_data = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0};
        set_in(12, 1'b1);
        run_check("post_reset", 12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
